// File: rtl/pc_select.sv
// Fetch PC selection: redirect muxing, next-PC prediction, fetch status and RUN/HALT/FAULT control.
// Define BTFNT_PREDICT_EN for backward-taken/forward-not-taken prediction of conditional jumps.
module pc_select #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        f_hlt,
  input  logic        f_instr_valid,
  input  logic        f_imem_error,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic        M_pred_taken,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  output logic [63:0] f_pc,
  output logic [63:0] F_predPC,
  output logic        f_pred_taken,
  output logic [2:0]  f_stat,
  output logic [1:0]  f_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_e      state_q, state_d;
  logic [63:0] pred_pc_q, pred_pc_d;
  logic [2:0]  stat_q, stat_d;
  logic        mispredict_s, ret_done_s, redirect_s;
  logic [2:0]  fetch_stat_s;
  logic [63:0] next_pc_s;

  assign mispredict_s = (M_icode == 4'h7) && (M_Cnd != M_pred_taken);
  assign ret_done_s   = (W_icode == 4'h9);
  assign redirect_s   = mispredict_s || ret_done_s;

  // PC mux and branch prediction for the instruction at f_pc
  always_comb begin
    f_pc         = F_predPC;
    f_pred_taken = 1'b0;
    if (mispredict_s) begin
      f_pc = M_valA;
    end else if (ret_done_s) begin
      f_pc = W_valM;
    end else begin
      f_pc = pred_pc_q;
    end
    if (f_icode == 4'h7) begin
      if (f_ifun == 4'h0) begin
        f_pred_taken = 1'b1;
      end else begin
`ifdef BTFNT_PREDICT_EN
        f_pred_taken = (f_valC < f_valP);
`else
        f_pred_taken = 1'b1;
`endif
      end
    end else begin
      f_pred_taken = 1'b0;
    end
  end

  // Fetch status and predicted next PC
  always_comb begin
    fetch_stat_s = STAT_AOK;
    next_pc_s    = f_valP;
    if (f_imem_error) begin
      fetch_stat_s = STAT_ADR;
    end else if (!f_instr_valid) begin
      fetch_stat_s = STAT_INS;
    end else if (f_hlt || (f_icode == 4'h0)) begin
      fetch_stat_s = STAT_HLT;
    end else begin
      fetch_stat_s = STAT_AOK;
    end
    if ((f_icode == 4'h8) || ((f_icode == 4'h7) && f_pred_taken)) begin
      next_pc_s = f_valC;
    end else begin
      next_pc_s = f_valP;
    end
  end

  // Next-state: a redirect squashes stall and any speculative halt/fault
  always_comb begin
    state_d   = state_q;
    pred_pc_d = pred_pc_q;
    stat_d    = stat_q;
    if (redirect_s || ((state_q == ST_RUN) && !F_stall)) begin
      pred_pc_d = next_pc_s;
      stat_d    = fetch_stat_s;
      case (fetch_stat_s)
        STAT_ADR, STAT_INS: state_d = ST_FAULT;
        STAT_HLT:           state_d = ST_HALT;
        default:            state_d = ST_RUN;
      endcase
    end else begin
      state_d   = state_q;
      pred_pc_d = pred_pc_q;
      stat_d    = stat_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pred_pc_q <= RESET_PC;
      stat_q    <= STAT_AOK;
    end else begin
      state_q   <= state_d;
      pred_pc_q <= pred_pc_d;
      stat_q    <= stat_d;
    end
  end

  assign F_predPC = pred_pc_q;
  assign f_state  = state_q;
  assign f_stat   = ((state_q == ST_RUN) || redirect_s) ? fetch_stat_s : stat_q;

endmodule

// File: tb/tb_pc_select.sv
// Directed self-checking bench for pc_select with hand-computed expectations.
module tb_pc_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_stall;
  logic [3:0]  f_icode, f_ifun;
  logic [63:0] f_valC, f_valP;
  logic        f_hlt, f_instr_valid, f_imem_error;
  logic [3:0]  M_icode;
  logic        M_Cnd, M_pred_taken;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [63:0] f_pc, F_predPC;
  logic        f_pred_taken;
  logic [2:0]  f_stat;
  logic [1:0]  f_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic        exp_taken;
  logic [63:0] big;

  pc_select #(.RESET_PC(64'd0)) dut (
    .clk(clk), .rst(rst), .F_stall(F_stall),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP),
    .f_hlt(f_hlt), .f_instr_valid(f_instr_valid), .f_imem_error(f_imem_error),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_pred_taken(M_pred_taken), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .f_pc(f_pc), .F_predPC(F_predPC), .f_pred_taken(f_pred_taken),
    .f_stat(f_stat), .f_state(f_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc, input logic [63:0] vp);
    f_icode = ic; f_ifun = fn; f_valC = vc; f_valP = vp;
    f_hlt = 1'b0; f_instr_valid = 1'b1; f_imem_error = 1'b0;
  endtask

  initial begin
    rst = 1'b1; F_stall = 1'b0;
    fetch(4'h1, 4'h0, 64'd0, 64'h1);
    M_icode = 4'h0; M_Cnd = 1'b0; M_pred_taken = 1'b0; M_valA = 64'd0;
    W_icode = 4'h0; W_valM = 64'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("reset_predpc", F_predPC, 64'd0);
    check_eq("reset_fpc", f_pc, 64'd0);
    check_eq("reset_state", {62'd0, f_state}, 64'd0);
    check_eq("nop_stat", {61'd0, f_stat}, 64'd1);

    // sequential fetch: nop then OPq
    tick();
    check_eq("seq_pc1", F_predPC, 64'h1);
    fetch(4'h6, 4'h0, 64'd0, 64'h3);
    tick();
    check_eq("seq_pc3", F_predPC, 64'h3);
    check_eq("seq_stat", {61'd0, f_stat}, 64'd1);
    check_eq("seq_state", {62'd0, f_state}, 64'd0);

    // call, then ret redirect overriding a stall
    fetch(4'h8, 4'h0, 64'h100, 64'h29);
    #1;
    check_eq("call_taken", {63'd0, f_pred_taken}, 64'd0);
    tick();
    check_eq("call_target", F_predPC, 64'h100);
    fetch(4'h1, 4'h0, 64'd0, 64'h2A);
    F_stall = 1'b1; W_icode = 4'h9; W_valM = 64'h29;
    #1;
    check_eq("ret_fpc", f_pc, 64'h29);
    tick();
    check_eq("ret_predpc", F_predPC, 64'h2A);
    F_stall = 1'b0; W_icode = 4'h0;

    // forward jne
`ifdef BTFNT_PREDICT_EN
    exp_taken = 1'b0;
`else
    exp_taken = 1'b1;
`endif
    fetch(4'h7, 4'h4, 64'h40, 64'h2B);
    #1;
    check_eq("jne_fwd_taken", {63'd0, f_pred_taken}, {63'd0, exp_taken});
    tick();
    check_eq("jne_fwd_pred", F_predPC, exp_taken ? 64'h40 : 64'h2B);
    // backward jne and forward jmp are taken in both configurations
    fetch(4'h7, 4'h4, 64'h10, 64'h50);
    #1;
    check_eq("jne_bwd_taken", {63'd0, f_pred_taken}, 64'd1);
    fetch(4'h7, 4'h0, 64'h90, 64'h50);
    #1;
    check_eq("jmp_taken", {63'd0, f_pred_taken}, 64'd1);
    // correctly predicted branch in M: no redirect
    M_icode = 4'h7; M_Cnd = 1'b1; M_pred_taken = 1'b1; M_valA = 64'h777;
    #1;
    check_eq("no_mispredict_fpc", f_pc, exp_taken ? 64'h40 : 64'h2B);
    // mispredict, with a simultaneous ret to check priority
    M_Cnd = ~exp_taken; M_pred_taken = exp_taken; M_valA = 64'h40;
    W_icode = 4'h9; W_valM = 64'h999;
    fetch(4'h1, 4'h0, 64'd0, 64'h41);
    #1;
    check_eq("mispredict_fpc", f_pc, 64'h40);
    tick();
    check_eq("mispredict_pred", F_predPC, 64'h41);
    M_icode = 4'h0; W_icode = 4'h0;

    // halt, frozen for 5 cycles, then squashed by a mispredict
    fetch(4'h0, 4'h0, 64'd0, 64'h2E);
    #1;
    check_eq("hlt_stat_comb", {61'd0, f_stat}, 64'd2);
    tick();
    check_eq("halt_state", {62'd0, f_state}, 64'd1);
    fetch(4'h1, 4'h0, 64'd0, 64'h77);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("halt_frozen_pc", F_predPC, 64'h2E);
      check_eq("halt_frozen_stat", {61'd0, f_stat}, 64'd2);
      check_eq("halt_frozen_state", {62'd0, f_state}, 64'd1);
    end
    M_icode = 4'h7; M_Cnd = 1'b0; M_pred_taken = 1'b1; M_valA = 64'h60;
    fetch(4'h1, 4'h0, 64'd0, 64'h61);
    #1;
    check_eq("halt_redirect_fpc", f_pc, 64'h60);
    tick();
    check_eq("halt_redirect_state", {62'd0, f_state}, 64'd0);
    check_eq("halt_redirect_pred", F_predPC, 64'h61);
    M_icode = 4'h0;

    // ADR beats INS; fault latches status; reset recovers
    fetch(4'h1, 4'h0, 64'd0, 64'h70);
    f_imem_error = 1'b1; f_instr_valid = 1'b0;
    #1;
    check_eq("adr_stat_comb", {61'd0, f_stat}, 64'd3);
    tick();
    check_eq("adr_state", {62'd0, f_state}, 64'd2);
    fetch(4'h1, 4'h0, 64'd0, 64'h71);
    #1;
    check_eq("adr_stat_latched", {61'd0, f_stat}, 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("fault_rst_state", {62'd0, f_state}, 64'd0);
    check_eq("fault_rst_pred", F_predPC, 64'd0);
    f_instr_valid = 1'b0;
    #1;
    check_eq("ins_stat_comb", {61'd0, f_stat}, 64'd4);
    tick();
    check_eq("ins_state", {62'd0, f_state}, 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // stall holds, then 64-bit wrap
    fetch(4'h1, 4'h0, 64'd0, 64'h10);
    tick();
    check_eq("pre_stall_pred", F_predPC, 64'h10);
    F_stall = 1'b1;
    fetch(4'h1, 4'h0, 64'd0, 64'h99);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_hold", F_predPC, 64'h10);
    end
    F_stall = 1'b0;
    big = 64'hFFFF_FFFF_FFFF_FFFF;
    big = big + 64'd1;
    fetch(4'h1, 4'h0, 64'd0, big);
    tick();
    check_eq("wrap_pred", F_predPC, 64'd0);
    check_eq("wrap_state", {62'd0, f_state}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
